// File: rtl/sched_pkg.sv
// +----------------------------------------------------------------------------+
// | sched_pkg: shared constants, state encoding and slot-2 hazard check.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package sched_pkg;

    localparam int          c_instr_w = 32;
    localparam logic [31:0] c_nop     = 32'h0000_0000;

    localparam int c_rd_msb  = 25;
    localparam int c_rd_lsb  = 21;
    localparam int c_rs1_msb = 20;
    localparam int c_rs1_lsb = 16;
    localparam int c_rs2_msb = 15;
    localparam int c_rs2_lsb = 11;

    typedef logic [1:0] sched_state_e;
    localparam sched_state_e c_st_idle  = 2'd0;
    localparam sched_state_e c_st_run   = 2'd1;
    localparam sched_state_e c_st_flush = 2'd2;

    // b may not pair with a when it touches the register a writes (r0 never conflicts).
    function automatic logic has_hazard(input logic [c_instr_w-1:0] a,
                                        input logic [c_instr_w-1:0] b);
        logic [4:0] a_rd;
        a_rd = a[c_rd_msb:c_rd_lsb];
        return (a != c_nop) && (a_rd != 5'd0) &&
               ((b[c_rs1_msb:c_rs1_lsb] == a_rd) ||
                (b[c_rs2_msb:c_rs2_lsb] == a_rd) ||
                (b[c_rd_msb:c_rd_lsb]   == a_rd));
    endfunction

endpackage

`default_nettype wire

// File: rtl/issue_fifo.sv
// +----------------------------------------------------------------------------+
// | issue_fifo: circular instruction buffer, one push and 0/1/2 pops per cycle. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module issue_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic [1:0]                 pop_n_i,
    output logic [W-1:0]               head0_o,
    output logic [W-1:0]               head1_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int c_addr_w = $clog2(DEPTH);
    localparam int c_cnt_w  = c_addr_w + 1;

    logic [W-1:0]          mem_q [DEPTH];
    logic [c_addr_w-1:0]   wr_ptr_q;
    logic [c_addr_w-1:0]   rd_ptr_q;
    logic [c_addr_w-1:0]   w_rd_next;
    logic [c_cnt_w-1:0]    count_q;

    assign w_rd_next = rd_ptr_q + c_addr_w'(1);
    assign head0_o   = mem_q[rd_ptr_q];
    assign head1_o   = mem_q[w_rd_next];
    assign count_o   = count_q;

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + c_addr_w'(push_i);
            rd_ptr_q <= rd_ptr_q + c_addr_w'(pop_n_i);
            count_q  <= count_q + c_cnt_w'(push_i) - c_cnt_w'(pop_n_i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/dual_issue_scheduler.sv
// +----------------------------------------------------------------------------+
// | dual_issue_scheduler: packs a single-wide stream into two issue slots.      |
// | Optional SCHED_STATS_EN adds saturating dual/single/stall counters.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module dual_issue_scheduler
    import sched_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int INSTR_W = 32,
    parameter int PC_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [INSTR_W-1:0]   instr_i,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic                 stall_i,
    input  logic                 flush_i,
    output logic [INSTR_W-1:0]   instruction_1_o,
    output logic [INSTR_W-1:0]   instruction_2_o,
    output logic [1:0]           issue_cnt_o,
    output logic [PC_W-1:0]      issue_pc_o
`ifdef SCHED_STATS_EN
    ,
    output logic [31:0]          stat_dual_o,
    output logic [31:0]          stat_single_o,
    output logic [31:0]          stat_stall_o
`endif
);

    localparam int                 c_cnt_w = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    logic [INSTR_W-1:0] w_head0, w_head1;
    logic [c_cnt_w-1:0] w_count, w_count_d;
    logic               w_push, w_issue, w_hazard, w_dual;
    logic [1:0]         w_pop_n;

    sched_state_e       state_q, state_d;
    logic               init_q;
    logic [INSTR_W-1:0] slot1_q, slot1_d, slot2_q, slot2_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [PC_W-1:0]    pc_q, pc_d;

    // init_q keeps ready low for the first cycle after reset release.
    assign instr_ready_o = init_q && (w_count < c_depth) && (state_q != c_st_flush) && !flush_i;
    assign w_push        = instr_valid_i && instr_ready_o;
    assign w_hazard      = has_hazard(w_head0, w_head1);
    assign w_issue       = !flush_i && !stall_i && (state_q == c_st_run) && (w_count != '0);
    assign w_dual        = w_issue && (w_count >= c_cnt_w'(2)) && !w_hazard;
    assign w_pop_n       = w_dual ? 2'd2 : (w_issue ? 2'd1 : 2'd0);
    assign w_count_d     = w_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop_n);

    issue_fifo #(
        .DEPTH (DEPTH),
        .W     (INSTR_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (flush_i),
        .push_i  (w_push),
        .data_i  (instr_i),
        .pop_n_i (w_pop_n),
        .head0_o (w_head0),
        .head1_o (w_head1),
        .count_o (w_count)
    );

    // IDLE looks at the registered count, so a fresh entry waits one cycle before issuing.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = c_st_flush;
        end else begin
            case (state_q)
                c_st_idle: if (w_count != '0)   state_d = c_st_run;
                c_st_run:  if (w_count_d == '0) state_d = c_st_idle;
                default:                        state_d = c_st_idle;
            endcase
        end
    end

    always_comb begin
        slot1_d = slot1_q;
        slot2_d = slot2_q;
        cnt_d   = cnt_q;
        pc_d    = pc_q;
        if (flush_i) begin
            slot1_d = '0;
            slot2_d = '0;
            cnt_d   = 2'd0;
        end else if (!stall_i) begin
            slot1_d = w_issue ? w_head0 : '0;
            slot2_d = w_dual  ? w_head1 : '0;
            cnt_d   = w_pop_n;
            pc_d    = pc_q + PC_W'(w_pop_n);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_st_idle;
            init_q  <= 1'b0;
            slot1_q <= '0;
            slot2_q <= '0;
            cnt_q   <= 2'd0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            slot1_q <= slot1_d;
            slot2_q <= slot2_d;
            cnt_q   <= cnt_d;
            pc_q    <= pc_d;
        end
    end

    assign instruction_1_o = slot1_q;
    assign instruction_2_o = slot2_q;
    assign issue_cnt_o     = cnt_q;
    assign issue_pc_o      = pc_q;

`ifdef SCHED_STATS_EN
    logic [31:0] stat_dual_q, stat_single_q, stat_stall_q;
    logic        w_split;

    assign w_split = w_issue && (w_count >= c_cnt_w'(2)) && w_hazard;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_dual_q   <= '0;
            stat_single_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (w_dual && (stat_dual_q != '1))
                stat_dual_q <= stat_dual_q + 32'd1;
            if (w_issue && !w_dual && (stat_single_q != '1))
                stat_single_q <= stat_single_q + 32'd1;
            if ((stall_i || w_split) && (stat_stall_q != '1))
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_dual_o   = stat_dual_q;
    assign stat_single_o = stat_single_q;
    assign stat_stall_o  = stat_stall_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dual_issue_scheduler.sv
// +----------------------------------------------------------------------------+
// | tb_dual_issue_scheduler: queue-based reference model plus directed vectors. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dual_issue_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] slot1, slot2;
    logic [1:0]  cnt;
    logic [4:0]  pc;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    dual_issue_scheduler #(
        .DEPTH   (8),
        .INSTR_W (32),
        .PC_W    (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .instr_i         (instr),
        .instr_valid_i   (instr_valid),
        .instr_ready_o   (instr_ready),
        .stall_i         (stall),
        .flush_i         (flush),
        .instruction_1_o (slot1),
        .instruction_2_o (slot2),
        .issue_cnt_o     (cnt),
        .issue_pc_o      (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of buffered instructions plus a few flags.
    logic [31:0] mq[$];
    logic [31:0] m_s1 = 32'h0;
    logic [31:0] m_s2 = 32'h0;
    int          m_cnt = 0;
    int          m_issued = 0;
    bit          m_init = 1'b0;
    bit          m_open = 1'b0;   // buffer has been non-empty long enough to issue
    bit          m_flushing = 1'b0;
    int          m_pre;
    bit          m_acc;

    function automatic bit hz(input logic [31:0] a, input logic [31:0] b);
        logic [4:0] rd;
        rd = a[25:21];
        return (a != 32'h0) && (rd != 5'd0) &&
               (b[20:16] == rd || b[15:11] == rd || b[25:21] == rd);
    endfunction

    function automatic bit m_ready_now();
        return m_init && (mq.size() < 8) && !m_flushing && !flush;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mq.delete();
            m_s1 = 32'h0; m_s2 = 32'h0; m_cnt = 0; m_issued = 0;
            m_init = 1'b0; m_open = 1'b0; m_flushing = 1'b0;
        end else begin
            m_pre = mq.size();
            m_acc = instr_valid && m_ready_now();
            if (flush) begin
                mq.delete();
                m_s1 = 32'h0; m_s2 = 32'h0; m_cnt = 0;
                m_flushing = 1'b1; m_open = 1'b0;
            end else begin
                if (!stall) begin
                    if (m_open && !m_flushing && m_pre > 0) begin
                        m_s1 = mq.pop_front(); m_s2 = 32'h0; m_cnt = 1;
                        if (mq.size() > 0 && !hz(m_s1, mq[0])) begin
                            m_s2 = mq.pop_front(); m_cnt = 2;
                        end
                        m_issued += m_cnt;
                    end else begin
                        m_s1 = 32'h0; m_s2 = 32'h0; m_cnt = 0;
                    end
                end
                if (m_acc) mq.push_back(instr);
                if (m_flushing)  m_open = 1'b0;
                else if (m_open) m_open = (mq.size() > 0);
                else             m_open = (m_pre > 0);
                m_flushing = 1'b0;
            end
            m_init = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("m_slot1", slot1, m_s1);
            chk("m_slot2", slot2, m_s2);
            chk("m_cnt",   32'(cnt), 32'(m_cnt));
            chk("m_pc",    32'(pc), 32'(m_issued % 32));
            chk("m_ready", 32'(instr_ready), 32'(m_ready_now()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        instr_valid = 1'b1;
        instr = d;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1);
    end

    initial begin
        repeat (3) tick();
        chk("rst_slot1", slot1, 32'h0);
        chk("rst_slot2", slot2, 32'h0);
        chk("rst_cnt",   32'(cnt), 32'd0);
        chk("rst_pc",    32'(pc), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        chk("ready_before_first_edge", 32'(instr_ready), 32'd0);
        tick();
        chk("ready_after_first_edge", 32'(instr_ready), 32'd1);

        // Independent pair issues together two cycles after the first push.
        push(32'h0022_0000);
        push(32'h0043_0000);
        instr_valid = 1'b0;
        tick();
        chk("dual_slot1", slot1, 32'h0022_0000);
        chk("dual_slot2", slot2, 32'h0043_0000);
        chk("dual_cnt",   32'(cnt), 32'd2);
        chk("dual_pc",    32'(pc), 32'd2);
        tick();
        chk("idle_cnt",   32'(cnt), 32'd0);

        // B reads A's destination r3: split across two cycles.
        push(32'h0060_0000);
        push(32'h0003_0000);
        instr_valid = 1'b0;
        tick();
        chk("haz_a_slot1", slot1, 32'h0060_0000);
        chk("haz_a_slot2", slot2, 32'h0);
        chk("haz_a_cnt",   32'(cnt), 32'd1);
        tick();
        chk("haz_b_slot1", slot1, 32'h0003_0000);
        chk("haz_b_cnt",   32'(cnt), 32'd1);
        chk("haz_b_pc",    32'(pc), 32'd4);
        tick();

        // Fill under stall, then drain two per cycle.
        stall = 1'b1;
        for (int i = 0; i < 8; i++) push(32'(32'h100 + i));
        instr_valid = 1'b0;
        chk("full_ready", 32'(instr_ready), 32'd0);
        push(32'hFFFF_FFFF);
        instr_valid = 1'b0;
        stall = 1'b0;
        tick();
        chk("drain_slot1", slot1, 32'h0000_0100);
        chk("drain_slot2", slot2, 32'h0000_0101);
        chk("drain_ready", 32'(instr_ready), 32'd1);
        repeat (3) tick();
        chk("drain_pc",    32'(pc), 32'd12);
        tick();

        // Asynchronous reset in the middle of issuing.
        push(32'h200);
        push(32'h201);
        push(32'h202);
        instr_valid = 1'b0;
        chk("pre_rst_slot1", slot1, 32'h0000_0200);
        rst_n = 1'b0;
        #1;
        chk("arst_slot1", slot1, 32'h0);
        chk("arst_slot2", slot2, 32'h0);
        chk("arst_cnt",   32'(cnt), 32'd0);
        chk("arst_pc",    32'(pc), 32'd0);
        chk("arst_ready", 32'(instr_ready), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_ready", 32'(instr_ready), 32'd0);
        tick();
        chk("arst_ready_back", 32'(instr_ready), 32'd1);

        // 17 dual-issue cycles: 34 mod 32 = 2.
        for (int r = 0; r < 4; r++) begin
            stall = 1'b1;
            for (int i = 0; i < 8; i++) push(32'(32'h300 + r * 8 + i));
            instr_valid = 1'b0;
            stall = 1'b0;
            repeat (5) tick();
        end
        chk("wrap_pc_32", 32'(pc), 32'd0);
        stall = 1'b1;
        push(32'h380);
        push(32'h381);
        instr_valid = 1'b0;
        stall = 1'b0;
        tick();
        chk("wrap_cnt", 32'(cnt), 32'd2);
        chk("wrap_pc",  32'(pc), 32'd2);
        tick();

        // Flush with five buffered, a stall and a concurrent push.
        stall = 1'b1;
        for (int i = 0; i < 5; i++) push(32'(32'h400 + i));
        instr_valid = 1'b0;
        stall = 1'b0;
        tick();
        stall = 1'b1;
        push(32'h405);
        push(32'h406);
        chk("held_slot1", slot1, 32'h0000_0400);
        flush = 1'b1;
        instr = 32'h0000_0777;
        #1;
        chk("flush_ready", 32'(instr_ready), 32'd0);
        tick();
        flush = 1'b0;
        instr_valid = 1'b0;
        chk("flush_slot1", slot1, 32'h0);
        chk("flush_slot2", slot2, 32'h0);
        chk("flush_cnt",   32'(cnt), 32'd0);
        chk("flush_pc",    32'(pc), 32'd4);
        chk("flush_state_ready", 32'(instr_ready), 32'd0);
        stall = 1'b0;
        tick();
        chk("post_flush_ready", 32'(instr_ready), 32'd1);
        repeat (4) tick();
        chk("post_flush_cnt", 32'(cnt), 32'd0);
        chk("post_flush_pc",  32'(pc), 32'd4);

        repeat (2) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
